alu_cmd_frontend: RTL

//   Upstream input stage for the 8-bit ALU datapath (opermux).
//   - Syncs the raw execute pushbutton and the board switches (8 data, 4 opcode).
//   - Debounces the button.
//   - On each clean press, captures one {opcode, operand} command and presents it to the ALU.
//   - Uses a valid/ready handshake, so each press executes exactly one ALU operation.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 36 +++
 rtl/alu_cmd_frontend.sv | 86 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcode encoding and command front-end FSM states.
package alu_pkg;
  localparam int ALU_W = 8;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] OP_AND  = 4'b0010;
  localparam logic [SEL_W-1:0] OP_OR   = 4'b0011;
  localparam logic [SEL_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [SEL_W-1:0] OP_NOT  = 4'b0101;
  localparam logic [SEL_W-1:0] OP_SHL  = 4'b0110;
  localparam logic [SEL_W-1:0] OP_SHR  = 4'b0111;
  localparam logic [SEL_W-1:0] OP_SAR  = 4'b1000;
  localparam logic [SEL_W-1:0] OP_ROL  = 4'b1001;
  localparam logic [SEL_W-1:0] OP_ROR  = 4'b1010;
  localparam logic [SEL_W-1:0] OP_INC  = 4'b1011;
  localparam logic [SEL_W-1:0] OP_DEC  = 4'b1100;
  localparam logic [SEL_W-1:0] OP_NEG  = 4'b1101;
  localparam logic [SEL_W-1:0] OP_PASS = 4'b1110;
  localparam logic [SEL_W-1:0] OP_LOAD = 4'b1111;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a bouncing button, filters it to a clean level
// and emits a one-cycle pulse on each clean 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic r_clean, r_rise;
  logic w_sync, w_flip;
  assign w_sync = r_sync[SYNC_STAGES-1];
  // the DEBOUNCE_CYCLES-th consecutive disagreeing cycle flips the level
  assign w_flip = (w_sync != r_clean) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], raw};
      r_cnt   <= (w_sync == r_clean || w_flip) ? '0 : r_cnt + CNT_W'(1);
      r_clean <= r_clean ^ w_flip;
      r_rise  <= w_flip & ~r_clean;
    end
  end
  assign clean = r_clean;
  assign rise  = r_rise;
endmodule

// File: rtl/alu_cmd_frontend.sv
// alu_cmd_frontend: turns each debounced execute press into one {opcode, operand}
// command for the ALU, delivered over a valid/ready handshake.
module alu_cmd_frontend
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_exec,
  input  logic [ALU_W-1:0] sw_data,
  input  logic [SEL_W-1:0] sw_sel,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [SEL_W-1:0] cmd_sel,
  output logic [ALU_W-1:0] cmd_data,
  output logic             busy,
  output logic [7:0]       cmd_count
);
  logic w_clean, w_rise;
  logic [SEL_W+ALU_W-1:0] r_sw [SYNC_STAGES];
  state_t r_state;
  logic r_valid, r_busy;
  logic [SEL_W-1:0] r_sel;
  logic [ALU_W-1:0] r_data;
  logic [7:0] r_count;
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn (
    .clk(clk),
    .reset(reset),
    .raw(btn_exec),
    .clean(w_clean),
    .rise(w_rise)
  );
  // switches are only synchronised; they are sampled once, at capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sw[i] <= '0;
    end else begin
      r_sw[0] <= {sw_sel, sw_data};
      for (int i = 1; i < SYNC_STAGES; i++) r_sw[i] <= r_sw[i-1];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_sel   <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_rise) begin
          {r_sel, r_data} <= r_sw[SYNC_STAGES-1];
          r_valid <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: if (cmd_ready) begin
          r_valid <= 1'b0;
          r_count <= r_count + 8'd1;
          r_busy  <= w_clean;
          r_state <= w_clean ? HOLD : IDLE;
        end
        HOLD: if (!w_clean) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign cmd_valid = r_valid;
  assign cmd_sel   = r_sel;
  assign cmd_data  = r_data;
  assign busy      = r_busy;
  assign cmd_count = r_count;
endmodule
